// File: rtl/led_adder_switch_frontend.sv
// Switch input front end for the 2-bit LED adder: synchronise, debounce,
// and present stable operands with a registered sum and change tracking.
module led_adder_switch_frontend #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw1,
    input  logic       sw2,
    input  logic       sw3,
    input  logic       sw4,
    output logic [3:0] sw_stable,
    output logic [1:0] operand_a,
    output logic [1:0] operand_b,
    output logic [2:0] sum,
    output logic       sum_valid,
    output logic [7:0] change_count
);

    localparam int unsigned NUM_SW = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_SW-1:0]            raw;
    logic [NUM_SW-1:0]            sync_q1;
    logic [NUM_SW-1:0]            sync_q2;
    logic [NUM_SW-1:0][CNT_W-1:0] cnt;
    logic [NUM_SW-1:0]            stable;
    logic [NUM_SW-1:0]            stable_prev;
    logic                         stable_changed;

    assign raw = {sw4, sw3, sw2, sw1};

    // Two-flop synchroniser, nothing between the stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

    // Per-bit debounce: a mismatch must persist DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            stable <= '0;
        end else begin
            for (int i = 0; i < NUM_SW; i++) begin
                if (sync_q2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync_q2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign sw_stable = stable;
    assign operand_a = stable[1:0];
    assign operand_b = stable[3:2];

    // Any difference from last cycle's stable value is one change event.
    assign stable_changed = (stable != stable_prev);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_prev  <= '0;
            sum          <= '0;
            sum_valid    <= 1'b0;
            change_count <= '0;
        end else begin
            stable_prev <= stable;
            sum_valid   <= stable_changed;
            if (stable_changed) begin
                sum          <= 3'(operand_a) + 3'(operand_b);
                change_count <= change_count + 8'(1);
            end
        end
    end

endmodule

// File: tb/tb_led_adder_switch_frontend.sv
// Directed self-checking bench for led_adder_switch_frontend with DEBOUNCE_CYCLES = 4.
module tb_led_adder_switch_frontend;

    logic       clk;
    logic       rst;
    logic       sw1, sw2, sw3, sw4;
    logic [3:0] sw_stable;
    logic [1:0] operand_a, operand_b;
    logic [2:0] sum;
    logic       sum_valid;
    logic [7:0] change_count;

    int tests;
    int fails;
    int pulses;

    led_adder_switch_frontend #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw1         (sw1),
        .sw2         (sw2),
        .sw3         (sw3),
        .sw4         (sw4),
        .sw_stable   (sw_stable),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .sum         (sum),
        .sum_valid   (sum_valid),
        .change_count(change_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts sum_valid pulses of the previous cycle.
    always @(posedge clk) begin
        if (sum_valid === 1'b1) pulses <= pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_sw(input logic [3:0] v);
        {sw4, sw3, sw2, sw1} = v;
    endtask

    task automatic do_reset(input logic [3:0] v);
        set_sw(v);
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] v;
        logic [3:0] exp_stable;
        logic [3:0] prev_stable;
        logic [2:0] exp_sum;
        logic [7:0] exp_cnt;
        int         p0;

        tests  = 0;
        fails  = 0;
        pulses = 0;
        rst    = 1'b1;
        set_sw(4'b1111);

        // Reset held with all switches high.
        cyc(4);
        chk("rst_stable", 32'(sw_stable), 32'h0);
        chk("rst_sum", 32'(sum), 32'h0);
        chk("rst_valid", 32'(sum_valid), 32'h0);
        chk("rst_count", 32'(change_count), 32'h0);
        chk("rst_opa", 32'(operand_a), 32'h0);
        rst = 1'b0;
        cyc(5);
        chk("rel_stable_early", 32'(sw_stable), 32'h0);
        cyc(1);
        chk("rel_stable", 32'(sw_stable), 32'hf);
        chk("rel_opb", 32'(operand_b), 32'h3);
        chk("rel_valid_early", 32'(sum_valid), 32'h0);
        cyc(1);
        chk("rel_sum", 32'(sum), 32'h6);
        chk("rel_valid", 32'(sum_valid), 32'h1);
        chk("rel_count", 32'(change_count), 32'h1);
        cyc(1);
        chk("rel_valid_drop", 32'(sum_valid), 32'h0);

        // Three-cycle glitch on sw1 must be rejected.
        do_reset(4'b0000);
        p0 = pulses;
        sw1 = 1'b1;
        cyc(3);
        sw1 = 1'b0;
        cyc(20);
        chk("glitch_stable", 32'(sw_stable), 32'h0);
        chk("glitch_pulses", 32'(pulses - p0), 32'h0);
        chk("glitch_count", 32'(change_count), 32'h0);

        // Walk {sw2,sw1,sw4,sw3} through every value.
        prev_stable = 4'b0000;
        exp_cnt     = 8'd0;
        for (int k = 0; k < 16; k++) begin
            v = 4'(k);
            {sw2, sw1, sw4, sw3} = v;
            p0 = pulses;
            cyc(10);
            exp_stable = {v[1:0], v[3:2]};
            exp_sum    = 3'(v[3:2]) + 3'(v[1:0]);
            if (exp_stable != prev_stable) exp_cnt = exp_cnt + 8'd1;
            chk("walk_stable", 32'(sw_stable), 32'(exp_stable));
            chk("walk_sum", 32'(sum), 32'(exp_sum));
            chk("walk_pulses", 32'(pulses - p0), (exp_stable != prev_stable) ? 32'h1 : 32'h0);
            chk("walk_count", 32'(change_count), 32'(exp_cnt));
            prev_stable = exp_stable;
        end

        // All four switches rise together: a single event.
        do_reset(4'b0000);
        p0 = pulses;
        set_sw(4'b1111);
        cyc(10);
        chk("simul_pulses", 32'(pulses - p0), 32'h1);
        chk("simul_sum", 32'(sum), 32'h6);
        chk("simul_count", 32'(change_count), 32'h1);

        // 256 clean sw3 toggles wrap the change counter.
        do_reset(4'b0000);
        for (int k = 0; k < 256; k++) begin
            sw3 = ~sw3;
            cyc(8);
            chk("wrap_sum", 32'(sum), (k % 2 == 0) ? 32'h1 : 32'h0);
            chk("wrap_count", 32'(change_count), 32'((k + 1) % 256));
        end

        // Reset mid-debounce discards the partial count on sw4.
        do_reset(4'b0000);
        sw4 = 1'b1;
        cyc(4);
        chk("mid_pre_stable", 32'(sw_stable), 32'h0);
        rst = 1'b1;
        cyc(2);
        chk("mid_in_rst", 32'(sw_stable), 32'h0);
        rst = 1'b0;
        cyc(5);
        chk("mid_requal_early", 32'(sw_stable), 32'h0);
        cyc(1);
        chk("mid_requal", 32'(sw_stable), 32'h8);
        cyc(1);
        chk("mid_sum", 32'(sum), 32'h2);
        chk("mid_valid", 32'(sum_valid), 32'h1);
        chk("mid_count", 32'(change_count), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
